feedback_rx: RTL and testbench
==============================

Name: feedback_rx

Overview:
- Receive side of the 5-word feedback packet the reward builder emits: fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID, in that order, one 16-bit word per strobe.
- Validates cluster and destination, then commits the sender's battery status and fValue into the node's byte-addressed memory as two word writes.
- Sits between the radio/link word stream and the shared memory port; handshakes with the preceding stage via done_prev/done.

Parameters:
- BATT_BASE, 'h148, byte base of the per-node battery table; entry address = BATT_BASE + src*2
- VAL_BASE, 'h1C8, byte base of the per-neighbour fValue table; entry address = VAL_BASE + src*2
- TIMEOUT, 16, max clock cycles allowed between consecutive data_valid strobes inside a packet

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- done_prev  in  1  level; high arms the receiver for one packet
- data_valid  in  1  one-cycle strobe; data_in holds a valid packet word
- data_in  in  16  packet word
- MY_NODE_ID  in  16  this node's ID
- MY_CLUSTER_ID  in  16  this node's cluster ID
- address  out  16  memory byte address for the write
- data_out  out  16  memory write data
- wr_en  out  1  one-cycle write strobe
- drop  out  1  one-cycle pulse; packet rejected or aborted
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

Behaviour:
- Reset (async, nreset low): state=IDLE; address=0, data_out=0, wr_en=0, drop=0, done=0, busy=0; captured words and timeout counter cleared. Reset mid-packet discards the packet with no write and no drop pulse.
- All state and outputs are registered. wr_en and drop are high for exactly one cycle.
- IDLE: go to CAP_SRC when done_prev=1. data_valid is ignored in IDLE.
- CAP_SRC, CAP_BATT, CAP_VAL, CAP_CLUS, CAP_DEST: each state latches data_in on data_valid and advances to the next state. CAP_DEST advances to CHECK.
- data_valid in the same cycle as the IDLE->CAP_SRC transition is not captured.
- Timeout:
  - A counter clears on entry to CAP_SRC and on every data_valid, and increments every other cycle in a CAP_* state.
  - When the counter reaches TIMEOUT, go to DROP.
  - The first word also has TIMEOUT cycles to arrive.
- CHECK (1 cycle): accept only if all of the following hold:
  - cluster == MY_CLUSTER_ID
  - dest == MY_NODE_ID (broadcast, see Optional Feature)
  - src != MY_NODE_ID
  - Accept -> WR_BATT; otherwise -> DROP.
- WR_BATT (1 cycle): address = BATT_BASE + src*2, data_out = batt, wr_en=1 -> WR_VAL.
- WR_VAL (1 cycle): address = VAL_BASE + src*2, data_out = fValue, wr_en=1 -> DONE.
- Address arithmetic: 16-bit and truncated modulo 2^16. src*2 is computed as {src[14:0],1'b0}. Wraparound is not flagged.
- address and data_out hold their last values outside the write states.
- DROP (1 cycle): drop=1 -> DONE.
- DONE: done=1. Stay in DONE while done_prev=1; go to IDLE when done_prev=0.
- A rejected packet still ends in DONE, so the upstream handshake always completes.
- Latency: done rises 3 cycles after the data_valid that carries fdestinationID (CHECK, WR_BATT, WR_VAL), or 2 cycles on reject.

Optional Feature:
- Macro: FEEDBACK_RX_BROADCAST_EN
- Defined: dest == 16'hFFFF is also accepted, subject to the same cluster and src checks.
- Undefined: 16'hFFFF is treated as an ordinary ID and accepted only if MY_NODE_ID == 16'hFFFF.

Test Plan:
- Normal packet:
  - Setup: MY_NODE_ID=3, MY_CLUSTER_ID=1, done_prev=1.
  - Stimulus: words 5, 'h0064, 'h0A0A, 1, 3.
  - Required: writes ('h152,'h0064) then ('h1D2,'h0A0A), each with wr_en for one cycle; done 3 cycles after the last word; drop never asserted.
- Cluster mismatch: same packet with cluster=2 -> no wr_en, drop pulse 1 cycle after CHECK, done asserted.
- Self-source: src=3 with MY_NODE_ID=3 -> rejected, drop=1 for one cycle, no writes.
- Timeout: two words sent, then 16 idle cycles -> drop pulse, DONE, no writes; after done_prev=0, IDLE (busy=0).
- Broadcast:
  - Stimulus: dest='hFFFF.
  - Required with FEEDBACK_RX_BROADCAST_EN defined: both writes occur.
  - Required without it: drop pulse, no writes.
- Async reset mid-packet:
  - Stimulus: nreset low after the 3rd word.
  - Required: all outputs 0 immediately. After release, a fresh valid packet with src='h8001 gives address 'h148+'h0002='h014A (src*2 truncated) and completes normally.

Source files
------------

// File: rtl/feedback_rx_if.sv
// Word-stream, node-identity and memory-write signals of the feedback packet receiver.
// master drives the packet stream and identity; slave is the receiver itself.
interface feedback_rx_if;
  logic        done_prev;
  logic        data_valid;
  logic [15:0] data_in;
  logic [15:0] MY_NODE_ID;
  logic [15:0] MY_CLUSTER_ID;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        wr_en;
  logic        drop;
  logic        busy;
  logic        done;

  modport master (
    output done_prev, data_valid, data_in, MY_NODE_ID, MY_CLUSTER_ID,
    input  address, data_out, wr_en, drop, busy, done
  );

  modport slave (
    input  done_prev, data_valid, data_in, MY_NODE_ID, MY_CLUSTER_ID,
    output address, data_out, wr_en, drop, busy, done
  );
endinterface

// File: rtl/feedback_rx.sv
// Receives the 5-word feedback packet, validates cluster/destination/source and commits
// battery status and fValue as two memory writes. FEEDBACK_RX_BROADCAST_EN accepts dest 16'hFFFF.
module feedback_rx #(
  parameter logic [15:0] BATT_BASE = 16'h0148,
  parameter logic [15:0] VAL_BASE  = 16'h01C8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic         clock,
  input  logic         nreset,
  feedback_rx_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    CAP_SRC,
    CAP_BATT,
    CAP_VAL,
    CAP_CLUS,
    CAP_DEST,
    CHECK,
    WR_BATT,
    WR_VAL,
    DROP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] batt_q, batt_d;
  logic [15:0] val_q, val_d;
  logic [15:0] clus_q, clus_d;
  logic [15:0] dest_q, dest_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;
  logic        drop_q, drop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        dest_ok;
  logic        accept;
  logic [15:0] src_x2;

  // Source doubled into a byte offset; the top bit falls off so addresses wrap mod 2^16.
  assign src_x2 = {src_q[14:0], 1'b0};

`ifdef FEEDBACK_RX_BROADCAST_EN
  assign dest_ok = (dest_q == bus.MY_NODE_ID) || (dest_q == 16'hFFFF);
`else
  assign dest_ok = (dest_q == bus.MY_NODE_ID);
`endif

  assign accept = (clus_q == bus.MY_CLUSTER_ID) && dest_ok && (src_q != bus.MY_NODE_ID);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      src_q   <= '0;
      batt_q  <= '0;
      val_q   <= '0;
      clus_q  <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      batt_q  <= batt_d;
      val_q   <= val_d;
      clus_q  <= clus_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    batt_d  = batt_q;
    val_d   = val_q;
    clus_d  = clus_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.done_prev) begin
          state_d = CAP_SRC;
          cnt_d   = '0;
        end
      end

      CAP_SRC, CAP_BATT, CAP_VAL, CAP_CLUS, CAP_DEST: begin
        if (bus.data_valid) begin
          cnt_d = '0;
          unique case (state_q)
            CAP_SRC:  begin src_d  = bus.data_in; state_d = CAP_BATT; end
            CAP_BATT: begin batt_d = bus.data_in; state_d = CAP_VAL;  end
            CAP_VAL:  begin val_d  = bus.data_in; state_d = CAP_CLUS; end
            CAP_CLUS: begin clus_d = bus.data_in; state_d = CAP_DEST; end
            default:  begin dest_d = bus.data_in; state_d = CHECK;    end
          endcase
        end else begin
          // Counter holds idle cycles since the last strobe; abort when it reaches TIMEOUT.
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT)) begin
            state_d = DROP;
          end
        end
      end

      CHECK:   state_d = accept ? WR_BATT : DROP;
      WR_BATT: state_d = WR_VAL;
      WR_VAL:  state_d = DONE;
      DROP:    state_d = DONE;

      DONE: begin
        if (!bus.done_prev) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    drop_d  = (state_d == DROP);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE) && (state_d != DONE);

    if (state_d == WR_BATT) begin
      addr_d  = BATT_BASE + src_x2;
      wdata_d = batt_q;
      wr_en_d = 1'b1;
    end else if (state_d == WR_VAL) begin
      addr_d  = VAL_BASE + src_x2;
      wdata_d = val_q;
      wr_en_d = 1'b1;
    end
  end

  assign bus.address  = addr_q;
  assign bus.data_out = wdata_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.drop     = drop_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_feedback_rx.sv
// Directed bench for feedback_rx: accept, reject, timeout, broadcast and async reset cases.
module tb_feedback_rx;

  logic clk = 1'b0;
  logic nreset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          drop_cnt = 0;

  feedback_rx_if bus ();

  feedback_rx #(
    .BATT_BASE (16'h0148),
    .VAL_BASE  (16'h01C8),
    .TIMEOUT   (16)
  ) dut (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa.push_back(bus.address);
      wd.push_back(bus.data_out);
    end
    if (bus.drop === 1'b1) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},  32'(bus.address),  32'h0);
    chk({tag, "_data"},  32'(bus.data_out), 32'h0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en),    32'h0);
    chk({tag, "_drop"},  32'(bus.drop),     32'h0);
    chk({tag, "_done"},  32'(bus.done),     32'h0);
    chk({tag, "_busy"},  32'(bus.busy),     32'h0);
  endtask

  task automatic start_pkt(input string tag);
    wa.delete();
    wd.delete();
    drop_cnt = 0;
    @(negedge clk);
    bus.done_prev = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'h1);
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data_in    = w;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] s, input logic [15:0] b, input logic [15:0] v,
                          input logic [15:0] c, input logic [15:0] d);
    send(s);
    send(b);
    send(v);
    send(c);
    send(d);
  endtask

  // Expects the cycle-exact accept sequence after the destination word was taken.
  task automatic expect_accept(input string tag, input logic [15:0] a0, input logic [15:0] d0,
                               input logic [15:0] a1, input logic [15:0] d1);
    chk({tag, "_check_done"}, 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    chk({tag, "_wb_wr"},   32'(bus.wr_en),    32'h1);
    chk({tag, "_wb_addr"}, 32'(bus.address),  32'(a0));
    chk({tag, "_wb_data"}, 32'(bus.data_out), 32'(d0));
    chk({tag, "_wb_done"}, 32'(bus.done),     32'h0);
    @(posedge clk); #1;
    chk({tag, "_wv_wr"},   32'(bus.wr_en),    32'h1);
    chk({tag, "_wv_addr"}, 32'(bus.address),  32'(a1));
    chk({tag, "_wv_data"}, 32'(bus.data_out), 32'(d1));
    chk({tag, "_wv_done"}, 32'(bus.done),     32'h0);
    @(posedge clk); #1;
    chk({tag, "_done"},      32'(bus.done),    32'h1);
    chk({tag, "_done_wr"},   32'(bus.wr_en),   32'h0);
    chk({tag, "_done_busy"}, 32'(bus.busy),    32'h0);
    chk({tag, "_addr_hold"}, 32'(bus.address), 32'(a1));
    chk({tag, "_nwr"},       32'(wa.size()),   32'h2);
    chk({tag, "_ndrop"},     32'(drop_cnt),    32'h0);
    if (wa.size() == 2) begin
      chk({tag, "_log_a0"}, 32'(wa[0]), 32'(a0));
      chk({tag, "_log_d0"}, 32'(wd[0]), 32'(d0));
      chk({tag, "_log_a1"}, 32'(wa[1]), 32'(a1));
      chk({tag, "_log_d1"}, 32'(wd[1]), 32'(d1));
    end
  endtask

  task automatic expect_reject(input string tag);
    chk({tag, "_check_drop"}, 32'(bus.drop), 32'h0);
    @(posedge clk); #1;
    chk({tag, "_drop"},      32'(bus.drop),  32'h1);
    chk({tag, "_drop_done"}, 32'(bus.done),  32'h0);
    @(posedge clk); #1;
    chk({tag, "_done"},      32'(bus.done),  32'h1);
    chk({tag, "_drop_end"},  32'(bus.drop),  32'h0);
    chk({tag, "_nwr"},       32'(wa.size()), 32'h0);
    chk({tag, "_ndrop"},     32'(drop_cnt),  32'h1);
  endtask

  task automatic end_pkt(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_wait"}, 32'(bus.done), 32'h1);
    @(negedge clk);
    bus.done_prev = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    nreset            = 1'b0;
    bus.done_prev     = 1'b0;
    bus.data_valid    = 1'b0;
    bus.data_in       = '0;
    bus.MY_NODE_ID    = 16'd3;
    bus.MY_CLUSTER_ID = 16'd1;

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Normal packet: src 5 -> 0x148+10, 0x1C8+10.
    start_pkt("norm");
    send_pkt(16'd5, 16'h0064, 16'h0A0A, 16'd1, 16'd3);
    expect_accept("norm", 16'h0152, 16'h0064, 16'h01D2, 16'h0A0A);
    end_pkt("norm");

    start_pkt("clus");
    send_pkt(16'd5, 16'h0064, 16'h0A0A, 16'd2, 16'd3);
    expect_reject("clus");
    end_pkt("clus");

    start_pkt("self");
    send_pkt(16'd3, 16'h0064, 16'h0A0A, 16'd1, 16'd3);
    expect_reject("self");
    end_pkt("self");

    start_pkt("tmo");
    send(16'd5);
    send(16'h0064);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_pre_drop", 32'(bus.drop), 32'h0);
    chk("tmo_pre_busy", 32'(bus.busy), 32'h1);
    @(posedge clk); #1;
    chk("tmo_drop", 32'(bus.drop), 32'h1);
    @(posedge clk); #1;
    chk("tmo_done", 32'(bus.done), 32'h1);
    chk("tmo_nwr",   32'(wa.size()), 32'h0);
    chk("tmo_ndrop", 32'(drop_cnt),  32'h1);
    end_pkt("tmo");

    // Broadcast dest from src 7 -> 0x148+14, 0x1C8+14.
    start_pkt("bcast");
    send_pkt(16'd7, 16'h1234, 16'h5678, 16'd1, 16'hFFFF);
`ifdef FEEDBACK_RX_BROADCAST_EN
    expect_accept("bcast", 16'h0156, 16'h1234, 16'h01D6, 16'h5678);
`else
    expect_reject("bcast");
`endif
    end_pkt("bcast");

    start_pkt("rst");
    send(16'd9);
    send(16'h0011);
    send(16'h0022);
    #2;
    nreset = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    bus.done_prev = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    chk("rst_nwr",   32'(wa.size()), 32'h0);
    chk("rst_ndrop", 32'(drop_cnt),  32'h0);

    // Strobe coincident with arming must not be captured as the source word.
    wa.delete();
    wd.delete();
    drop_cnt = 0;
    @(negedge clk);
    bus.done_prev  = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 16'hDEAD;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    chk("wrap_busy_start", 32'(bus.busy), 32'h1);
    send_pkt(16'h8001, 16'h1111, 16'h2222, 16'd1, 16'd3);
    expect_accept("wrap", 16'h014A, 16'h1111, 16'h01CA, 16'h2222);
    end_pkt("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
